// File: rtl/packet_resolver_pkg.sv
// packet_resolver_pkg: types and helpers shared by the packet resolver.
//   fifo_word_t : one buffered beat {data, sop, eop, empty}
//   wr_state_t  : write-side state (IDLE / RECV / DROP)
//   ptr_full()  : full test on wrap-bit pointers
package packet_resolver_pkg;

  localparam int AST_DWIDTH  = 64;
  localparam int EMPTY_WIDTH = $clog2(AST_DWIDTH / 8);

  typedef struct packed {
    logic [AST_DWIDTH-1:0]  data;
    logic                   sop;
    logic                   eop;
    logic [EMPTY_WIDTH-1:0] empty;
  } fifo_word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DROP = 2'd2
  } wr_state_t;

  // Pointers carry aw address bits plus one wrap bit; full when only the
  // wrap bit differs.
  function automatic logic ptr_full(input logic [31:0] a, input logic [31:0] b,
                                    input int unsigned aw);
    logic [31:0] diff;
    diff = (a ^ b) & ((32'd1 << (aw + 1)) - 32'd1);
    return diff == (32'd1 << aw);
  endfunction

endpackage

// File: rtl/packet_resolver_if.sv
// avalon_st_if: Avalon-ST bus bundle.
//   sink modport : data/valid/startofpacket/endofpacket/empty/channel in, ready out
//   src modport  : data/valid/startofpacket/endofpacket/empty/channel out, ready in
interface avalon_st_if #(
  parameter int DWIDTH = 64,
  parameter int CWIDTH = 1,
  parameter int EWIDTH = $clog2(DWIDTH / 8)
);
  logic [DWIDTH-1:0] data;
  logic              valid;
  logic              ready;
  logic              startofpacket;
  logic              endofpacket;
  logic [EWIDTH-1:0] empty;
  logic [CWIDTH-1:0] channel;

  modport sink (input data, valid, startofpacket, endofpacket, empty, channel,
                output ready);
  modport src  (output data, valid, startofpacket, endofpacket, empty, channel,
                input ready);
endinterface

// File: rtl/packet_resolver_ram.sv
// packet_resolver_ram: simple dual-port RAM, one write port, one registered
// read port with read enable (rdata holds while re is low).
//   clk, rst_n        : clock, async active-low reset (clears rdata only)
//   we, waddr, wdata  : write port
//   re, raddr, rdata  : read port, data valid the cycle after re
module packet_resolver_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/packet_resolver.sv
// packet_resolver: store-and-forward stage after the packet classifier.
// Each packet is buffered whole while channel[0] is ORed over its beats; at
// endofpacket it is committed (match) or discarded (no match). Committed
// packets are replayed in order on the source bus with valid/ready flow
// control. Overflow, missing eop and stray beats are dropped, never stalled.
//   clk_i, arst_n_i : clock, async active-low reset (sync deassert inside)
//   ast_sink_if     : classifier stream in (ready is always 1 out of reset)
//   ast_src_if      : resolved stream out (channel always 0)
//   fwd_cnt_o, drop_cnt_o : saturating packet counters, present only when
//                           PACKET_RESOLVER_STATS_EN is defined
module packet_resolver #(
  parameter int AST_DWIDTH    = 64,
  parameter int CHANNEL_WIDTH = 1,
  parameter int FIFO_DEPTH    = 256
) (
  input  logic        clk_i,
  input  logic        arst_n_i,
`ifdef PACKET_RESOLVER_STATS_EN
  output logic [15:0] fwd_cnt_o,
  output logic [15:0] drop_cnt_o,
`endif
  avalon_st_if.sink   ast_sink_if,
  avalon_st_if.src    ast_src_if
);
  import packet_resolver_pkg::*;

  localparam int          EMPTY_WIDTH = $clog2(AST_DWIDTH / 8);
  localparam int unsigned AW          = $clog2(FIFO_DEPTH);
  localparam int          WORD_W      = AST_DWIDTH + 2 + EMPTY_WIDTH;

  logic [1:0]               rst_sync;
  logic                     rst_n;
  logic                     ready_r, beat, sop, eop;
  logic [CHANNEL_WIDTH-1:0] ch;
  wr_state_t                state, state_n;
  logic [AW:0]              wr_ptr, wr_ptr_n, commit_ptr, commit_n, rd_ptr;
  logic                     match, match_n, we, start, abandon;
  logic                     full, full_at_commit;
  logic [AW-1:0]            waddr;
  logic                     re, out_vld;
  logic [WORD_W-1:0]        wdata, rdata;

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) rst_sync <= '0;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign ast_sink_if.ready = ready_r;
  assign beat  = ast_sink_if.valid & ready_r;
  assign sop   = ast_sink_if.startofpacket;
  assign eop   = ast_sink_if.endofpacket;
  assign ch    = ast_sink_if.channel;
  assign wdata = {ast_sink_if.data, sop, eop, ast_sink_if.empty};

  assign full           = ptr_full(32'(wr_ptr), 32'(rd_ptr), AW);
  assign full_at_commit = ptr_full(32'(commit_ptr), 32'(rd_ptr), AW);

  always_comb begin
    state_n  = state;
    wr_ptr_n = wr_ptr;
    commit_n = commit_ptr;
    match_n  = match;
    we       = 1'b0;
    waddr    = wr_ptr[AW-1:0];
    start    = 1'b0;
    abandon  = 1'b0;
    if (beat) begin
      if (state == RECV && !sop) begin
        if (full) begin
          abandon = 1'b1;
          state_n = eop ? IDLE : DROP;
        end else begin
          we       = 1'b1;
          wr_ptr_n = wr_ptr + 1'b1;
          if (eop) begin
            state_n = IDLE;
            if (match | ch[0]) commit_n = wr_ptr + 1'b1;
            else               abandon  = 1'b1;
          end else begin
            match_n = match | ch[0];
          end
        end
      end else if (sop) begin
        start = 1'b1;
      end else if (eop && state == DROP) begin
        state_n = IDLE;
      end
    end
    // Every sop (re)starts at commit_ptr, which also discards any partial
    // packet left by a missing eop.
    if (start) begin
      waddr = commit_ptr[AW-1:0];
      if (full_at_commit) begin
        abandon = 1'b1;
        state_n = eop ? IDLE : DROP;
      end else begin
        we       = 1'b1;
        wr_ptr_n = commit_ptr + 1'b1;
        if (eop) begin
          state_n = IDLE;
          if (ch[0]) commit_n = commit_ptr + 1'b1;
          else       abandon  = 1'b1;
        end else begin
          state_n = RECV;
          match_n = ch[0];
        end
      end
    end
    if (abandon) wr_ptr_n = commit_ptr;
  end

  // The RAM read register doubles as the output register: a read is issued
  // whenever it is empty or being drained, and holds its word while stalled.
  assign re = (rd_ptr != commit_ptr) && (!out_vld || ast_src_if.ready);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      match      <= 1'b0;
      ready_r    <= 1'b0;
      out_vld    <= 1'b0;
    end else begin
      state      <= state_n;
      wr_ptr     <= wr_ptr_n;
      commit_ptr <= commit_n;
      match      <= match_n;
      ready_r    <= 1'b1;
      out_vld    <= re | (out_vld & ~ast_src_if.ready);
      if (re) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  packet_resolver_ram #(.WIDTH(WORD_W), .DEPTH(FIFO_DEPTH)) u_ram (
    .clk   (clk_i),
    .rst_n (rst_n),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata),
    .re    (re),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rdata)
  );

  assign ast_src_if.valid         = out_vld;
  assign ast_src_if.data          = rdata[WORD_W-1 -: AST_DWIDTH];
  assign ast_src_if.startofpacket = rdata[EMPTY_WIDTH+1];
  assign ast_src_if.endofpacket   = rdata[EMPTY_WIDTH];
  assign ast_src_if.empty         = rdata[EMPTY_WIDTH-1:0];
  assign ast_src_if.channel       = '0;

`ifdef PACKET_RESOLVER_STATS_EN
  logic [1:0] drop_inc;
  // A restart that is itself a single-beat no-match packet drops two.
  assign drop_inc = {1'b0, beat && state == RECV && sop} + {1'b0, abandon};

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      fwd_cnt_o  <= '0;
      drop_cnt_o <= '0;
    end else begin
      if (commit_n != commit_ptr && fwd_cnt_o != 16'hFFFF)
        fwd_cnt_o <= fwd_cnt_o + 16'd1;
      if (drop_cnt_o > 16'hFFFF - {14'd0, drop_inc}) drop_cnt_o <= 16'hFFFF;
      else                                           drop_cnt_o <= drop_cnt_o + {14'd0, drop_inc};
    end
  end
`endif
endmodule

// File: tb/tb_packet_resolver.sv
module tb_packet_resolver;
  import packet_resolver_pkg::*;

  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  avalon_st_if #(.DWIDTH(AST_DWIDTH), .CWIDTH(1)) snk ();
  avalon_st_if #(.DWIDTH(AST_DWIDTH), .CWIDTH(1)) src ();

`ifdef PACKET_RESOLVER_STATS_EN
  logic [15:0] fwd_cnt, drop_cnt;
  int exp_fwd = 0, exp_drop = 0;
`endif

  packet_resolver #(.AST_DWIDTH(AST_DWIDTH), .CHANNEL_WIDTH(1), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .arst_n_i    (arst_n),
`ifdef PACKET_RESOLVER_STATS_EN
    .fwd_cnt_o   (fwd_cnt),
    .drop_cnt_o  (drop_cnt),
`endif
    .ast_sink_if (snk),
    .ast_src_if  (src)
  );

  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Reference model: packets are reassembled from the beat stream and whole
  // matching packets are pushed onto the expected queue.
  fifo_word_t exp_q[$];
  fifo_word_t cur[$];
  bit in_pkt = 0, pmatch = 0;

  task automatic model_beat(input fifo_word_t w, input logic c);
    if (w.sop) begin
`ifdef PACKET_RESOLVER_STATS_EN
      if (in_pkt) exp_drop++;
`endif
      cur.delete(); in_pkt = 1; pmatch = 0;
    end
    if (!in_pkt) return;
    if (cur.size() >= DEPTH) begin
`ifdef PACKET_RESOLVER_STATS_EN
      exp_drop++;
`endif
      cur.delete(); in_pkt = 0;
      return;
    end
    cur.push_back(w);
    pmatch = pmatch | c;
    if (w.eop) begin
      if (pmatch) begin
        foreach (cur[i]) exp_q.push_back(cur[i]);
`ifdef PACKET_RESOLVER_STATS_EN
        exp_fwd++;
      end else begin
        exp_drop++;
`endif
      end
      cur.delete(); in_pkt = 0;
    end
  endtask

  int drv_cyc;
  task automatic drive_beat(input logic [AST_DWIDTH-1:0] d, input logic s, input logic e,
                            input logic [EMPTY_WIDTH-1:0] em, input logic c);
    fifo_word_t w;
    w.data = d; w.sop = s; w.eop = e; w.empty = em;
    snk.valid = 1'b1; snk.data = d; snk.startofpacket = s; snk.endofpacket = e;
    snk.empty = em; snk.channel = c;
    checks++;
    if (snk.ready !== 1'b1) begin
      errors++;
      $display("FAIL sink_ready: got %b required 1 at cycle %0d", snk.ready, cyc);
    end else begin
      model_beat(w, c);
    end
    drv_cyc = cyc;
    @(posedge clk); #1;
    snk.valid = 1'b0; snk.startofpacket = 1'b0; snk.endofpacket = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  int ready_mode = 1;  // 0 low, 1 high, 2 random
  initial begin
    src.ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       src.ready = 1'b0;
        1:       src.ready = 1'b1;
        default: src.ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: pops the scoreboard on each accepted output beat and checks
  // that a stalled beat is held unchanged.
  bit lat_arm = 0;
  int lat_cyc = -1;
  bit stalled = 0;
  fifo_word_t held, ev;
  initial begin
    forever begin
      @(negedge clk);
      if (!arst_n) begin
        stalled = 0;
      end else begin
        if (stalled) begin
          checks++;
          if (src.valid !== 1'b1 || src.data !== held.data || src.startofpacket !== held.sop ||
              src.endofpacket !== held.eop || src.empty !== held.empty) begin
            errors++;
            $display("FAIL stall_hold: got valid=%b data=%h sop=%b eop=%b empty=%0d required valid=1 data=%h sop=%b eop=%b empty=%0d",
                     src.valid, src.data, src.startofpacket, src.endofpacket, src.empty,
                     held.data, held.sop, held.eop, held.empty);
          end
        end
        if (src.valid === 1'b1) begin
          if (lat_arm) begin lat_cyc = cyc; lat_arm = 0; end
          if (src.ready === 1'b1) begin
            stalled = 0;
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL out_beat: got unexpected beat data=%h required no beat", src.data);
            end else begin
              ev = exp_q.pop_front();
              if (src.data !== ev.data || src.startofpacket !== ev.sop || src.endofpacket !== ev.eop ||
                  src.empty !== ev.empty || src.channel !== 1'b0) begin
                errors++;
                $display("FAIL out_beat: got data=%h sop=%b eop=%b empty=%0d ch=%b required data=%h sop=%b eop=%b empty=%0d ch=0",
                         src.data, src.startofpacket, src.endofpacket, src.empty, src.channel,
                         ev.data, ev.sop, ev.eop, ev.empty);
              end
            end
          end else begin
            stalled = 1;
            held.data = src.data; held.sop = src.startofpacket;
            held.eop = src.endofpacket; held.empty = src.empty;
          end
        end else begin
          stalled = 0;
        end
      end
    end
  end

  task automatic drain(input string name);
    int k;
    k = 0;
    ready_mode = 1;
    while ((exp_q.size() != 0 || src.valid === 1'b1) && k < 2000) begin
      @(posedge clk); #1; k++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_%s: got %0d beats outstanding required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    while (snk.ready !== 1'b1 && k < 10) begin @(posedge clk); #1; k++; end
    checks++;
    if (snk.ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: got sink ready=%b required 1", snk.ready);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (src.valid !== 1'b0 || snk.ready !== 1'b0 || src.data !== '0 || src.startofpacket !== 1'b0 ||
        src.endofpacket !== 1'b0 || src.empty !== '0 || src.channel !== 1'b0) begin
      errors++;
      $display("FAIL %s: got valid=%b ready=%b data=%h sop=%b eop=%b empty=%0d ch=%b required all 0",
               name, src.valid, snk.ready, src.data, src.startofpacket, src.endofpacket,
               src.empty, src.channel);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, eop_cyc, len, k;
    bit noeop;
    snk.valid = 1'b0; snk.data = '0; snk.startofpacket = 1'b0; snk.endofpacket = 1'b0;
    snk.empty = '0; snk.channel = 1'b0;

    #23;
    check_reset_outputs("reset_state");
    arst_n = 1'b1;
    wait_ready();

    // 4 beats, match on beat 3 only, empty 3 on eop; latency eop -> valid is 2
    lat_cyc = -1; lat_arm = 1;
    for (int i = 1; i <= 4; i++)
      drive_beat(64'(i), i == 1, i == 4, (i == 4) ? 3'd3 : 3'd0, i == 3);
    eop_cyc = drv_cyc;
    drain("t1");
    checks++;
    if (lat_cyc - eop_cyc != 2) begin
      errors++;
      $display("FAIL latency: got %0d cycles required 2", lat_cyc - eop_cyc);
    end

    // unmatched 4-beat packet, then matched 2-beat packet
    for (int i = 0; i < 4; i++) drive_beat(64'h100 + 64'(i), i == 0, i == 3, 3'd0, 1'b0);
    drive_beat(64'h200, 1'b1, 1'b0, 3'd1, 1'b1);
    drive_beat(64'h201, 1'b0, 1'b1, 3'd5, 1'b0);
    drain("t2");

    // overflow: 40-beat packet into a 32-word buffer, then 3-beat packet
    for (int i = 0; i < 40; i++) drive_beat(64'h300 + 64'(i), i == 0, i == 39, 3'd0, 1'b1);
    for (int i = 0; i < 3; i++) drive_beat(64'h400 + 64'(i), i == 0, i == 2, 3'd2, i == 1);
    drain("t3");

    // 40-cycle source stall while three 8-beat packets arrive back-to-back
    ready_mode = 0;
    idle(1);
    t0 = cyc;
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 8; i++)
        drive_beat(64'h500 + 64'(p * 16 + i), i == 0, i == 7, 3'(i), i == 4);
    while (cyc - t0 < 40) idle(1);
    drain("t4");

    // missing eop: matched partial packet interrupted by a new sop
    drive_beat(64'h600, 1'b1, 1'b0, 3'd0, 1'b1);
    drive_beat(64'h601, 1'b0, 1'b0, 3'd0, 1'b0);
    drive_beat(64'h602, 1'b1, 1'b0, 3'd0, 1'b1);
    drive_beat(64'h603, 1'b0, 1'b1, 3'd4, 1'b0);
    drain("t5");

    // randomized traffic with random source backpressure
    ready_mode = 2;
    for (int p = 0; p < 60; p++) begin
      len = $urandom_range(1, 6);
      k = 0;
      while (exp_q.size() + len + 1 > DEPTH && k < 1000) begin idle(1); k++; end
      if (k >= 1000) begin
        checks++; errors++;
        $display("FAIL space_wait: got %0d queued required <= %0d", exp_q.size(), DEPTH - len - 1);
      end
      if ($urandom_range(0, 7) == 0)
        drive_beat({$urandom, $urandom}, 1'b0, $urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), 1'b1);
      noeop = ($urandom_range(0, 7) == 0);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        drive_beat({$urandom, $urandom}, b == 0, (b == len - 1) && !noeop,
                   3'($urandom_range(0, 7)), $urandom_range(0, 3) == 0);
      end
      idle($urandom_range(0, 3));
    end
    drain("random");

`ifdef PACKET_RESOLVER_STATS_EN
    checks++;
    if (fwd_cnt !== 16'(exp_fwd) || drop_cnt !== 16'(exp_drop)) begin
      errors++;
      $display("FAIL stats: got fwd=%0d drop=%0d required fwd=%0d drop=%0d",
               fwd_cnt, drop_cnt, exp_fwd, exp_drop);
    end
`endif

    // async reset mid-readout and mid-packet
    ready_mode = 0;
    for (int i = 0; i < 4; i++) drive_beat(64'h700 + 64'(i), i == 0, i == 3, 3'd0, 1'b1);
    drive_beat(64'h710, 1'b1, 1'b0, 3'd0, 1'b1);
    drive_beat(64'h711, 1'b0, 1'b0, 3'd0, 1'b0);
    idle(2);
    checks++;
    if (src.valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_valid: got %b required 1", src.valid);
    end
    #3;
    arst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    exp_q.delete(); cur.delete(); in_pkt = 0; pmatch = 0;
`ifdef PACKET_RESOLVER_STATS_EN
    exp_fwd = 0; exp_drop = 0;
`endif
    ready_mode = 1;
    idle(3);
    arst_n = 1'b1;
    wait_ready();
    idle(20);
    for (int i = 0; i < 3; i++) drive_beat(64'h800 + 64'(i), i == 0, i == 2, 3'd7, i == 2);
    drain("post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/packet_resolver.md
Name: packet_resolver

Overview:
- Store-and-forward stage directly downstream of the packet classifier.
- Buffers each Avalon-ST packet whole; ORs the classifier's channel bit across all beats of the packet.
- At endofpacket, commits the packet (match seen) or discards it (no match).
- Committed packets are replayed on the source interface in order, with standard valid/ready backpressure.

Parameters:
AST_DWIDTH, 64, data width of sink and source streams (bits)
CHANNEL_WIDTH, 1, channel width; bit 0 is the match flag from the classifier
FIFO_DEPTH, 256, buffer words, power of two; largest packet accepted in words
EMPTY_WIDTH, $clog2(AST_DWIDTH/8), derived localparam, not overridable

Ports:
clk_i  input  1  clock
arst_n_i  input  1  asynchronous active-low reset
ast_sink_if  avalon_st_if.sink  interface  classifier output: data, valid, startofpacket, endofpacket, empty, channel in; ready out
ast_src_if  avalon_st_if.src  interface  resolved stream: data, valid, startofpacket, endofpacket, empty, channel out; ready in

Behaviour:
- Reset (async assert, sync deassert inside block): src valid/sop/eop/data/empty/channel = 0; sink ready = 0; all pointers 0; write FSM = IDLE.
- sink ready = 1 in every cycle out of reset. Overflow is handled by dropping, never by stalling.
- Beat accepted = sink valid & ready.
- Pointers are log2(FIFO_DEPTH)+1 bits with a wrap bit: wr_ptr (speculative), commit_ptr, rd_ptr.
  - full: wr_ptr and rd_ptr differ only in MSB.
  - committed data available: rd_ptr != commit_ptr.
- Write FSM states IDLE, RECV, DROP:
  - IDLE + sop: write beat at pkt_start=commit_ptr, match = channel[0], go RECV. Sop+eop in the same beat is resolved immediately, as at RECV eop.
  - IDLE + beat without sop: ignore it.
  - RECV + beat: write the beat, match |= channel[0].
    - On eop: if the final match is 1, commit_ptr <= wr_ptr+1; otherwise wr_ptr <= commit_ptr. Go IDLE.
  - RECV + beat while full: wr_ptr <= commit_ptr, go DROP. If this beat is eop, go IDLE instead.
  - RECV + sop again (missing eop): rewind wr_ptr to commit_ptr, restart the packet with this beat, stay RECV.
  - DROP: discard beats until eop, then go IDLE. A sop in DROP restarts as in IDLE.
- Latency: matched eop accepted in cycle N → commit visible at N+1 → first beat has src valid in cycle N+2 (src ready high, buffer otherwise empty).
- Read side:
  - 1-cycle RAM read plus output register with prefetch, so throughput is 1 beat/cycle under continuous ready.
  - While valid & !ready, all src fields stay stable.
  - src channel = 0 on every beat, since the match flag is consumed here.
  - Read and commit in the same cycle are legal. rd_ptr never passes commit_ptr, so uncommitted words are never output.
- Sink fields are written verbatim into the buffer word {data, sop, eop, empty}. src sop/eop/empty reproduce them exactly.

Optional Feature:
- Macro PACKET_RESOLVER_STATS_EN.
- Defined: adds output ports fwd_cnt_o [15:0] and drop_cnt_o [15:0], both saturating at 16'hFFFF and reset to 0.
  - fwd_cnt_o increments on each commit.
  - drop_cnt_o increments on each no-match discard, overflow drop, or missing-eop restart.
- Undefined: ports and counters are absent; datapath behaviour is identical.

Decomposition:
- Package packet_resolver_pkg holds:
  - typedef fifo_word_t struct {data, sop, eop, empty}, parameterised via localparams in the package (AST_DWIDTH 64)
  - typedef wr_state_t enum {IDLE, RECV, DROP}
  - function ptr_full()
- Sub-module packet_resolver_ram: simple dual-port RAM, registered read, one write port and one read port, inferable as block RAM.

Test Plan:
- 4-beat packet, data 64'h1..64'h4, channel=1 on beat 3 only, empty=3 on eop → src emits 4 identical beats with sop on beat 1, eop + empty=3 on beat 4, channel 0; first valid 2 cycles after eop.
- 4-beat packet with channel=0 throughout, then 2-beat packet with channel=1 → only the 2-beat packet appears; commit_ptr advanced by 2 only.
- FIFO_DEPTH=16: 20-beat matched packet, then 3-beat matched packet → first packet fully absent, second delivered intact; drop_cnt_o=1 (STATS_EN).
- src ready low for 40 cycles while three matched 8-beat packets arrive back-to-back → sink ready stays 1; after ready rises, 24 beats in order, fields stable during stalls.
- Sop at beat 3 of an unterminated packet, new packet 2 beats matched → only the 2-beat packet output.
- arst_n_i low mid-packet and mid-readout → src valid drops in the same cycle without a clock edge; after release no stale beat is emitted.
